// File: rtl/entropy_block_collector.sv
// Collects NUM_WORDS 32-bit entropy words into one block (word 0 in the MSBs)
// and hands the block to the mixer over a syn/ack handshake.
module entropy_block_collector #(
    parameter int unsigned NUM_WORDS = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      entropy_enabled,
    input  logic                      entropy_syn,
    input  logic [31:0]               entropy_data,
    output logic                      entropy_ack,
    output logic                      block_syn,
    output logic [NUM_WORDS*32-1:0]   block_data,
    input  logic                      block_ack,
    output logic [31:0]               block_count,
    output logic                      collecting
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             capture;
    logic             ack_next;
    logic             syn_next;
    logic             count_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        ack_next   = 1'b0;
        syn_next   = 1'b0;
        count_inc  = 1'b0;
        // Dropping enable wins over everything, including a pending block_ack.
        if (!enable) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = COLLECT;
                    idx_next   = '0;
                end
                COLLECT: begin
                    if (entropy_enabled && entropy_syn && !entropy_ack) begin
                        capture  = 1'b1;
                        ack_next = 1'b1;
                        if (idx == LAST_IDX) begin
                            state_next = FULL;
                            syn_next   = 1'b1;
                            idx_next   = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (block_ack) begin
                        count_inc  = 1'b1;
                        idx_next   = '0;
                        state_next = COLLECT;
                    end else begin
                        syn_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            entropy_ack <= 1'b0;
            block_syn   <= 1'b0;
            collecting  <= 1'b0;
            block_count <= '0;
            block_data  <= '0;
        end else begin
            idx         <= idx_next;
            entropy_ack <= ack_next;
            block_syn   <= syn_next;
            collecting  <= (state_next == COLLECT);
            if (count_inc) begin
                block_count <= block_count + 32'd1;
            end
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                if (capture && idx == IDX_W'(w)) begin
                    block_data[(NUM_WORDS-1-w)*32 +: 32] <= entropy_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_entropy_block_collector.sv
// Scoreboard bench for entropy_block_collector: a queued word source feeds the
// DUT, expected blocks are queued as words are issued and checked on block_syn.
module tb_entropy_block_collector;

    localparam int unsigned NW = 16;
    localparam int unsigned BW = NW * 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          entropy_enabled = 1'b1;
    logic          entropy_syn = 1'b0;
    logic [31:0]   entropy_data = '0;
    logic          entropy_ack;
    logic          block_syn;
    logic [BW-1:0] block_data;
    logic          block_ack = 1'b0;
    logic [31:0]   block_count;
    logic          collecting;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned ack_cnt = 0;

    logic [31:0]   src_q[$];
    logic [BW-1:0] sb_q[$];

    entropy_block_collector #(.NUM_WORDS(NW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .entropy_enabled (entropy_enabled),
        .entropy_syn     (entropy_syn),
        .entropy_data    (entropy_data),
        .entropy_ack     (entropy_ack),
        .block_syn       (block_syn),
        .block_data      (block_data),
        .block_ack       (block_ack),
        .block_count     (block_count),
        .collecting      (collecting)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue NW source words and optionally the block they should form.
    task automatic push_words(input logic [31:0] base, input bit inc, input bit expect_block);
        logic [BW-1:0] blk;
        logic [31:0]   w;
        blk = '0;
        for (int i = 0; i < int'(NW); i++) begin
            w = inc ? base + 32'(i) : base;
            src_q.push_back(w);
            blk[(int'(NW)-1-i)*32 +: 32] = w;
        end
        if (expect_block) sb_q.push_back(blk);
    endtask

    task automatic wait_block(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (block_syn) return;
        end
        check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_acks(input int unsigned target);
        int unsigned seen;
        seen = 0;
        for (int i = 0; i < 400 && seen < target; i++) begin
            @(negedge clk);
            if (entropy_ack) seen++;
        end
        if (seen < target) check("ack_timeout", seen, target);
    endtask

    task automatic ack_block();
        block_ack = 1'b1;
        @(negedge clk);
        block_ack = 1'b0;
    endtask

    // Source model: holds syn while words remain, advances on each ack.
    initial begin
        forever begin
            @(negedge clk);
            if (entropy_ack && src_q.size() > 0) void'(src_q.pop_front());
            entropy_syn  = (src_q.size() > 0);
            entropy_data = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // Monitor: counts acks, checks pulse spacing, compares delivered blocks.
    initial begin
        logic prev_ack;
        logic prev_syn;
        prev_ack = 1'b0;
        prev_syn = 1'b0;
        forever begin
            @(negedge clk);
            if (entropy_ack) begin
                ack_cnt++;
                check("ack_pulse", prev_ack, 1'b0);
            end
            if (block_syn && !prev_syn) begin
                if (sb_q.size() == 0) check("block_unexpected", 1'b1, 1'b0);
                else check("block_data", block_data, sb_q.pop_front());
            end
            prev_ack = entropy_ack;
            prev_syn = block_syn;
        end
    end

    initial begin
        int n;
        int unsigned base;
        logic [BW-1:0] snap;
        int unsigned changes;

        repeat (3) @(negedge clk);
        check("rst_ack", entropy_ack, 1'b0);
        check("rst_syn", block_syn, 1'b0);
        check("rst_collecting", collecting, 1'b0);
        check("rst_count", block_count, 32'd0);
        check("rst_data", block_data, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Constant-data block: latency and ack count.
        push_words(32'hf1e2d3c4, 1'b0, 1'b1);
        base = ack_cnt;
        enable = 1'b1;
        wait_block("blk1", n);
        check("latency", n, 32);
        @(negedge clk);
        check("ack_count16", ack_cnt - base, 16);
        check("count_before_ack", block_count, 32'd0);

        // Incrementing data, ack, immediate restart.
        push_words(32'h0, 1'b1, 1'b1);
        ack_block();
        check("count_after_ack1", block_count, 32'd1);
        check("syn_after_ack1", block_syn, 1'b0);
        check("restart_collecting", collecting, 1'b1);
        wait_block("blk2", n);
        check("word0_msb", block_data[BW-1 -: 32], 32'h0);
        check("word15_lsb", block_data[31:0], 32'hf);

        // Source disabled mid-block for 10 cycles.
        push_words(32'h100, 1'b1, 1'b1);
        ack_block();
        check("count_after_ack2", block_count, 32'd2);
        wait_acks(5);
        entropy_enabled = 1'b0;
        base = ack_cnt;
        repeat (10) @(negedge clk);
        check("gap_acks", ack_cnt - base, 0);
        check("gap_collecting", collecting, 1'b1);
        entropy_enabled = 1'b1;
        wait_block("blk3", n);

        // Enable dropped after 7 words: partial block discarded.
        push_words(32'h200, 1'b1, 1'b0);
        ack_block();
        check("count_after_ack3", block_count, 32'd3);
        wait_acks(7);
        enable = 1'b0;
        @(negedge clk);
        check("disable_collecting", collecting, 1'b0);
        base = ack_cnt;
        repeat (5) @(negedge clk);
        check("disable_acks", ack_cnt - base, 0);
        src_q.delete();
        check("disable_count", block_count, 32'd3);
        push_words(32'h300, 1'b1, 1'b1);
        enable = 1'b1;
        wait_block("blk4", n);
        check("reenable_count", block_count, 32'd3);

        // Block held in FULL with source still offering words.
        push_words(32'h400, 1'b1, 1'b0);
        snap = block_data;
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (block_data !== snap || entropy_ack || !block_syn) changes++;
        end
        check("full_stable", changes, 0);
        block_ack = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        block_ack = 1'b0;
        check("ack_disable_collecting", collecting, 1'b0);
        check("ack_disable_syn", block_syn, 1'b0);
        check("ack_disable_count", block_count, 32'd3);
        src_q.delete();

        // Asynchronous reset mid-collection.
        push_words(32'h500, 1'b1, 1'b0);
        enable = 1'b1;
        wait_acks(3);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_ack", entropy_ack, 1'b0);
        check("arst_syn", block_syn, 1'b0);
        check("arst_collecting", collecting, 1'b0);
        check("arst_count", block_count, 32'd0);
        check("arst_data", block_data, '0);
        src_q.delete();
        enable = 1'b0;
        #7 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/entropy_block_collector.md
Name: entropy_block_collector

Overview:
- Sits directly downstream of an entropy source.
- Consumes 32-bit words over the source's syn/data/ack handshake and assembles NUM_WORDS words into one block.
- Presents the complete block to the mixer over a block-level syn/ack handshake.
- Gates collection on a software enable and on the source's enabled status, and keeps a running count of delivered blocks for status readout.

Parameters:
- NUM_WORDS, 16: words per block; legal range 2..64; block width is NUM_WORDS*32 bits (512 by default).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  collector enable from control register
- entropy_enabled  in  1  source reports it is running
- entropy_syn  in  1  source has a valid word on entropy_data
- entropy_data  in  32  source word
- entropy_ack  out  1  one-cycle pulse: word accepted
- block_syn  out  1  complete block valid on block_data
- block_data  out  NUM_WORDS*32  assembled block; word 0 in the MSBs
- block_ack  in  1  consumer has taken the block
- block_count  out  32  number of blocks delivered, wraps modulo 2^32
- collecting  out  1  high while in COLLECT state

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - state=IDLE
  - entropy_ack=0, block_syn=0, collecting=0
  - block_data=0, block_count=0
  - word index=0
- All outputs are registered.
- State IDLE:
  - entropy_ack=0, block_syn=0.
  - enable sampled 1 -> COLLECT, with word index cleared.
- State COLLECT:
  - Capture condition at an edge: enable=1, entropy_enabled=1, entropy_syn=1, and entropy_ack currently 0.
  - On capture:
    - entropy_data is written to word slot [index], bits (NUM_WORDS-1-index)*32+31 downto (NUM_WORDS-1-index)*32.
    - entropy_ack=1 for exactly the next cycle; index increments.
  - Because capture requires entropy_ack=0, throughput is at most 1 word per 2 cycles.
  - A source that holds syn high continuously is therefore accepted every other cycle.
  - Capture of the word at index NUM_WORDS-1 -> FULL, with block_syn=1 from the next cycle.
- entropy_enabled=0 in COLLECT:
  - No capture, ack stays 0.
  - Partial block and index are retained; collection resumes when the source is enabled again.
- entropy_syn=0 in COLLECT: wait, no other effect.
- State FULL:
  - block_syn=1, block_data stable; no words are captured (entropy_ack=0).
  - block_ack sampled 1 at an edge has these effects:
    - block_syn=0 next cycle and block_count += 1.
    - Index is cleared.
    - Next state is COLLECT if enable=1, else IDLE.
    - block_data is not cleared; it is overwritten word by word.
- block_ack while not in FULL: ignored, no count change.
- enable sampled 0 in any state:
  - Next state IDLE, index cleared.
  - block_syn=0 and entropy_ack=0 from the next cycle.
  - A partial or undelivered block is discarded and block_count is unchanged.
  - enable=0 takes priority over a simultaneous block_ack.
- Latency: with entropy_enabled=1 and syn held high, block_syn rises after 2*NUM_WORDS rising edges. The count starts at, and includes, the first edge that samples enable=1; that is 32 edges for the default.
- collecting=1 exactly when state=COLLECT.
- Asserting reset_n low mid-operation immediately forces all reset values, including block_count=0.

Test Plan:
- Reset, then source drives syn=1 with data=32'hf1e2d3c4 and entropy_enabled=1; raise enable:
  - entropy_ack pulses on alternate cycles, 16 pulses total.
  - block_syn rises after 32 edges; block_data = 16 copies of f1e2d3c4.
  - block_count stays 0 until block_ack.
- Source supplies incrementing data 0x00000000..0x0000000F; ack the block:
  - block_data[511:480]=0x0, block_data[31:0]=0xF.
  - block_count=1 and block_syn=0 on the cycle after block_ack.
  - Collection restarts immediately.
- Drop entropy_enabled after 5 words for 10 cycles, then restore:
  - No acks during the gap; collecting stays 1.
  - Words 5..15 complete the same block and the word order is intact.
- Deassert enable after 7 words:
  - State returns to IDLE with no further acks.
  - Re-enable: the next block begins at word 0, and block_count is unchanged.
- Hold block_ack=0 in FULL for 50 cycles with syn=1:
  - block_syn and block_data are stable; entropy_ack stays 0.
  - Assert block_ack and enable=0 in the same cycle: next state IDLE, block_count unchanged.
- Pulse reset_n low mid-collection, asynchronously and not aligned to clk:
  - All outputs return to 0 immediately; block_count=0.
